// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480 timing constants, phase enums and tile helper
package vga_pkg;

  // Horizontal timing in pixels
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FP_LEN     = 10'd16;
  localparam logic [9:0] H_SYNC_LEN   = 10'd96;
  localparam logic [9:0] H_BP_LEN     = 10'd48;
  localparam logic [9:0] H_FP_START   = H_VISIBLE;
  localparam logic [9:0] H_SYNC_START = H_FP_START + H_FP_LEN;
  localparam logic [9:0] H_BP_START   = H_SYNC_START + H_SYNC_LEN;
  localparam logic [9:0] H_TOTAL      = H_BP_START + H_BP_LEN;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;

  // Vertical timing in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FP_LEN     = 10'd10;
  localparam logic [9:0] V_SYNC_LEN   = 10'd2;
  localparam logic [9:0] V_BP_LEN     = 10'd33;
  localparam logic [9:0] V_FP_START   = V_VISIBLE;
  localparam logic [9:0] V_SYNC_START = V_FP_START + V_FP_LEN;
  localparam logic [9:0] V_BP_START   = V_SYNC_START + V_SYNC_LEN;
  localparam logic [9:0] V_TOTAL      = V_BP_START + V_BP_LEN;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

  // Tile grid: 32x32 pixel tiles, 20 across, 15 down
  localparam int unsigned VGA_TILE_SHIFT = 5;
  localparam int unsigned VGA_TILES_X    = 20;
  localparam int unsigned VGA_TILES_Y    = 15;

  typedef enum logic [1:0] {H_ACT, H_FP, H_SYNC, H_BP} h_phase_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SYNC, V_BP} v_phase_t;

  // Constant multiply as a sum of shifted copies; with a constant k this
  // reduces to a few adders (20 = 16 + 4 -> two terms).
  function automatic logic [8:0] shift_add_mul(input logic [9:0] a, input int unsigned k);
    logic [8:0] acc;
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      if (k[i]) acc = acc + 9'(a << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - scan position, sync and tile outputs of the VGA scan generator
interface vga_scan_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [8:0] TileIdx;
  logic       frame_start;
  logic       pix_ce;

  modport master (
    output DrawX, DrawY, hs, vs, blank, TileIdx, frame_start, pix_ce
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, TileIdx, frame_start, pix_ce
  );
endinterface

// File: rtl/pix_ce_gen.sv
// rtl/pix_ce_gen.sv - pixel tick enable; VGA_PIX_DIV2_EN selects Clk/2, otherwise every Clk
module pix_ce_gen (
  input  logic Clk,
  input  logic Reset,
  output logic pix_ce
);

`ifdef VGA_PIX_DIV2_EN
  logic ce_q;

  // Toggle each cycle; held low in reset so the first tick is the second cycle after release
  always_ff @(posedge Clk) begin
    if (Reset) ce_q <= 1'b0;
    else       ce_q <= ~ce_q;
  end

  assign pix_ce = ce_q;
`else
  logic unused_inputs;
  assign unused_inputs = Clk ^ Reset;
  assign pix_ce = 1'b1;
`endif

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - 640x480@60 VGA scan counter, sync/blank and tile index generator (option: VGA_PIX_DIV2_EN)
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned TILE_SHIFT = VGA_TILE_SHIFT,
  parameter int unsigned TILES_X    = VGA_TILES_X
) (
  input  logic           Clk,
  input  logic           Reset,
  vga_scan_gen_if.master vga
);

  logic       pix_ce;

  // Scan state
  logic       run_q;
  logic [9:0] h_q, v_q;
  h_phase_t   hst_q;
  v_phase_t   vst_q;

  // Registered outputs
  logic       hs_q, vs_q, blank_q, frame_start_q;
  logic [8:0] tile_q;

  // Next-state values
  logic [9:0] h_nxt, v_nxt;
  h_phase_t   hst_nxt;
  v_phase_t   vst_nxt;
  logic       h_wrap;
  logic       vis_nxt;
  logic [9:0] tile_row, tile_col;
  logic [8:0] tile_nxt;

  pix_ce_gen u_pix_ce_gen (
    .Clk    (Clk),
    .Reset  (Reset),
    .pix_ce (pix_ce)
  );

  // Next counter/phase values; the first tick after reset presents (0,0) instead of advancing
  always_comb begin
    h_nxt   = h_q;
    v_nxt   = v_q;
    hst_nxt = hst_q;
    vst_nxt = vst_q;
    h_wrap  = 1'b0;
    if (!run_q) begin
      h_nxt   = '0;
      v_nxt   = '0;
      hst_nxt = H_ACT;
      vst_nxt = V_ACT;
    end else begin
      if (h_q == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
      end else begin
        h_nxt  = h_q + 10'd1;
      end
      if (h_wrap) v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

      case (hst_q)
        H_ACT:   if (h_nxt == H_FP_START)   hst_nxt = H_FP;
        H_FP:    if (h_nxt == H_SYNC_START) hst_nxt = H_SYNC;
        H_SYNC:  if (h_nxt == H_BP_START)   hst_nxt = H_BP;
        H_BP:    if (h_nxt == 10'd0)        hst_nxt = H_ACT;
        default:                            hst_nxt = H_ACT;
      endcase

      if (h_wrap) begin
        case (vst_q)
          V_ACT:   if (v_nxt == V_FP_START)   vst_nxt = V_FP;
          V_FP:    if (v_nxt == V_SYNC_START) vst_nxt = V_SYNC;
          V_SYNC:  if (v_nxt == V_BP_START)   vst_nxt = V_BP;
          V_BP:    if (v_nxt == 10'd0)        vst_nxt = V_ACT;
          default:                            vst_nxt = V_ACT;
        endcase
      end
    end
  end

  // Tile index of the next pixel, shift/add only; zero outside the visible area
  always_comb begin
    vis_nxt  = (hst_nxt == H_ACT) && (vst_nxt == V_ACT);
    tile_row = v_nxt >> TILE_SHIFT;
    tile_col = h_nxt >> TILE_SHIFT;
    tile_nxt = vis_nxt ? (shift_add_mul(tile_row, TILES_X) + 9'(tile_col)) : 9'd0;
  end

  // Advance counters and phases on ticks and register decoded outputs in step with them
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_q         <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      hst_q         <= H_ACT;
      vst_q         <= V_ACT;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      tile_q        <= '0;
      frame_start_q <= 1'b0;
    end else if (pix_ce) begin
      run_q         <= 1'b1;
      h_q           <= h_nxt;
      v_q           <= v_nxt;
      hst_q         <= hst_nxt;
      vst_q         <= vst_nxt;
      hs_q          <= (hst_nxt != H_SYNC);
      vs_q          <= (vst_nxt != V_SYNC);
      blank_q       <= ~vis_nxt;
      tile_q        <= tile_nxt;
      frame_start_q <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  assign vga.DrawX       = h_q;
  assign vga.DrawY       = v_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.TileIdx     = tile_q;
  assign vga.frame_start = frame_start_q;
  assign vga.pix_ce      = pix_ce;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - directed self-checking bench for vga_scan_gen
module tb_vga_scan_gen;

`ifdef VGA_PIX_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  int   clk_cnt;

  vga_scan_gen_if vga ();

  vga_scan_gen dut (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vga)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial clk_cnt = 0;
  always @(posedge Clk) clk_cnt <= clk_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for the next tick edge and return just after it
  task automatic tick();
    int waits;
    waits = 0;
    @(negedge Clk);
    while (!vga.pix_ce && waits < 4) begin
      @(negedge Clk);
      waits++;
    end
    if (!vga.pix_ce) check("tick_timeout", 0, 1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int ex, ey, ticks, c0;
    int hs_low, hs_first, blank_first, vs_low, vs_first_y;
    int hs_bad, vs_bad, blank_bad, tile_bad, pos_bad, exp_tile;
    bit found;

    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_x", vga.DrawX, 0);
    check("rst_y", vga.DrawY, 0);
    check("rst_hs", vga.hs, 1);
    check("rst_vs", vga.vs, 1);
    check("rst_blank", vga.blank, 1);
    check("rst_tile", vga.TileIdx, 0);
    check("rst_fs", vga.frame_start, 0);
    check("rst_ce", vga.pix_ce, (DIV == 2) ? 0 : 1);

    Reset = 1'b0;
    tick();
    check("first_x", vga.DrawX, 0);
    check("first_y", vga.DrawY, 0);
    check("first_blank", vga.blank, 0);
    check("first_fs", vga.frame_start, 1);
    check("first_hs", vga.hs, 1);
    check("first_vs", vga.vs, 1);
    check("first_tile", vga.TileIdx, 0);

    ex = 0; ey = 0; ticks = 0; c0 = clk_cnt;
    hs_low = 0; hs_first = -1; blank_first = -1; vs_low = 0; vs_first_y = -1;
    hs_bad = 0; vs_bad = 0; blank_bad = 0; tile_bad = 0; pos_bad = 0;
    for (int n = 0; n < 430000; n++) begin
      tick();
      ticks++;
      if (vga.frame_start) break;
      ex = (ex == 799) ? 0 : ex + 1;
      if (ex == 0) ey = (ey == 524) ? 0 : ey + 1;
      if (vga.DrawX != ex || vga.DrawY != ey) pos_bad++;
      if (ey == 0) begin
        if (!vga.hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = ex;
        end
        if (vga.blank && blank_first < 0) blank_first = ex;
      end
      if (vga.hs != !(ex >= 656 && ex <= 751)) hs_bad++;
      if (vga.vs != !(ey == 490 || ey == 491)) vs_bad++;
      if (vga.blank != (ex >= 640 || ey >= 480)) blank_bad++;
      if (!vga.vs) begin
        vs_low++;
        if (vs_first_y < 0) vs_first_y = ey;
      end
      exp_tile = (ex < 640 && ey < 480) ? (ey / 32) * 20 + ex / 32 : 0;
      if (vga.TileIdx != exp_tile) tile_bad++;
      if (ex == 0 && ey == 1) begin
        check("line_y_inc", vga.DrawY, 1);
        check("line_clks", clk_cnt - c0, 800 * DIV);
      end
      if (ex == 100 && ey == 200) check("tile_100_200", vga.TileIdx, 123);
      if (ex == 639 && ey == 479) check("tile_639_479", vga.TileIdx, 299);
      if (ex == 700 && ey == 10)  check("tile_700", vga.TileIdx, 0);
    end
    check("frame_ticks", ticks, 420000);
    check("frame_x", vga.DrawX, 0);
    check("frame_y", vga.DrawY, 0);
    check("hs_low_ticks", hs_low, 96);
    check("hs_first_x", hs_first, 656);
    check("blank_first_x", blank_first, 640);
    check("vs_low_ticks", vs_low, 1600);
    check("vs_first_y", vs_first_y, 490);
    check("hs_window", hs_bad, 0);
    check("vs_window", vs_bad, 0);
    check("blank_window", blank_bad, 0);
    check("tile_map", tile_bad, 0);
    check("scan_order", pos_bad, 0);

    found = 1'b0;
    for (int n = 0; n < 300000; n++) begin
      if (vga.DrawX == 300 && vga.DrawY == 250) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_300_250", found, 1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst_x", vga.DrawX, 0);
    check("midrst_y", vga.DrawY, 0);
    check("midrst_blank", vga.blank, 1);
    check("midrst_hs", vga.hs, 1);
    check("midrst_fs", vga.frame_start, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    tick();
    check("restart_x", vga.DrawX, 0);
    check("restart_y", vga.DrawY, 0);
    check("restart_blank", vga.blank, 0);
    check("restart_fs", vga.frame_start, 1);
    tick();
    check("restart_x1", vga.DrawX, 1);
    check("restart_fs1", vga.frame_start, 0);

    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("ce_pattern", vga.pix_ce, (DIV == 1) ? 1 : (k % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
